// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encoding,
// instruction opcodes, ALU operation codes, write-back selects and the
// decoded-instruction record produced by mc_decode.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // Path class of an instruction through the FSM
    typedef enum logic [2:0] {
        C_ALU = 3'd0,
        C_LW  = 3'd1,
        C_SW  = 3'd2,
        C_BEQ = 3'd3,
        C_J   = 3'd4,
        C_JAL = 3'd5,
        C_ILL = 3'd6
    } op_class_t;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SLI   = 5'b00001;
    localparam logic [4:0] OP_J     = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_LW    = 5'b00100;
    localparam logic [4:0] OP_SW    = 5'b00101;
    localparam logic [4:0] OP_BEQ   = 5'b00110;
    localparam logic [4:0] OP_ADDI  = 5'b00111;
    localparam logic [4:0] OP_SLTI  = 5'b01000;
    localparam logic [4:0] OP_SLTIU = 5'b01001;
    localparam logic [4:0] OP_ORI   = 5'b01010;
    localparam logic [4:0] OP_XORI  = 5'b01011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_IMM  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b1000;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef struct packed {
        op_class_t  cls;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       sign_or_zero;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode lookup: maps a 5-bit opcode to its FSM path class and
// the datapath field values used from EXEC through WB.
// Ports: op (opcode in), dec (decoded record out).
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [4:0] op,
    output dec_t       dec
);

    // Opcode table; anything not listed decodes as illegal with neutral fields
    always_comb begin
        dec.cls          = C_ILL;
        dec.alu_op       = ALU_ADD;
        dec.alu_src      = 1'b0;
        dec.sign_or_zero = 1'b1;
        dec.reg_dst      = RD_RT;
        dec.mem_to_reg   = WB_ALU;
        case (op)
            OP_ADD:   begin dec.cls = C_ALU; dec.reg_dst = RD_RD; end
            OP_SLI:   begin dec.cls = C_ALU; dec.alu_op = ALU_SLL;  dec.alu_src = 1'b1; dec.sign_or_zero = 1'b0; end
            OP_ADDI:  begin dec.cls = C_ALU; dec.alu_op = ALU_IMM;  dec.alu_src = 1'b1; end
            OP_SLTI:  begin dec.cls = C_ALU; dec.alu_op = ALU_IMM;  dec.alu_src = 1'b1; end
            OP_SLTIU: begin dec.cls = C_ALU; dec.alu_op = ALU_SLTU; dec.alu_src = 1'b1; end
            OP_ORI:   begin dec.cls = C_ALU; dec.alu_op = ALU_OR;   dec.alu_src = 1'b1; dec.sign_or_zero = 1'b0; end
            OP_XORI:  begin dec.cls = C_ALU; dec.alu_op = ALU_XOR;  dec.alu_src = 1'b1; dec.sign_or_zero = 1'b0; end
            OP_LW:    begin dec.cls = C_LW;  dec.alu_op = ALU_IMM;  dec.alu_src = 1'b1; dec.mem_to_reg = WB_MEM; end
            OP_SW:    begin dec.cls = C_SW;  dec.alu_op = ALU_IMM;  dec.alu_src = 1'b1; end
            OP_BEQ:   begin dec.cls = C_BEQ; dec.alu_op = ALU_SUB; end
            OP_J:     begin dec.cls = C_J; end
            OP_JAL:   begin dec.cls = C_JAL; dec.reg_dst = RD_RA; dec.mem_to_reg = WB_PC; end
            default:  begin dec.cls = C_ILL; end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM (FETCH/DECODE/EXEC/MEM/WB[/TRAP]) with a
// memory wait watchdog that raises bus_err after WAIT_MAX stalled cycles.
// Ports: clk, reset_n (async active-low); opcode, zero, mem_ready in;
// datapath strobes, reg_dst/mem_to_reg/alu_op selects, state, instr_done,
// bus_err out; illegal_op out only when MC_CTRL_ILLEGAL_TRAP_EN is defined
// (undefined opcodes then trap instead of executing as a NOP).
// Strobes are decoded from the state register and are forced low while
// reset_n is low, so they drop asynchronously with reset.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       jump,
    output logic       branch,
    output logic       mem_read,
    output logic       mem_write,
    output logic       alu_src,
    output logic       reg_write,
    output logic       sign_or_zero,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [3:0] alu_op,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       bus_err
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    state_t        state_r;
    state_t        next_state_s;
    logic [4:0]    op_q_r;
    logic [CW-1:0] wait_cnt_r;
    logic [CW-1:0] wait_cnt_s;
    logic [4:0]    dec_op_s;
    dec_t          dec_s;
    logic          mem_phase_s;
    logic          timeout_s;

    // In DECODE the live opcode is decoded; afterwards the latched copy is used
    assign dec_op_s = (state_r == S_DECODE) ? opcode : op_q_r;

    mc_decode u_decode (
        .op  (dec_op_s),
        .dec (dec_s)
    );

    assign mem_phase_s = (state_r == S_FETCH) || (state_r == S_MEM);
    // A ready in the limit cycle wins over the timeout
    assign timeout_s   = mem_phase_s && !mem_ready && (wait_cnt_r == CW'(WAIT_MAX));
    assign state       = state_r;

    // Next-state, strobe decode and wait counter update
    always_comb begin
        next_state_s = state_r;
        wait_cnt_s   = {CW{1'b0}};
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        jump         = 1'b0;
        branch       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        alu_src      = 1'b0;
        reg_write    = 1'b0;
        sign_or_zero = 1'b1;
        reg_dst      = RD_RT;
        mem_to_reg   = WB_ALU;
        alu_op       = ALU_ADD;
        instr_done   = 1'b0;
        bus_err      = 1'b0;
        if (!reset_n) begin
            next_state_s = S_FETCH;
        end else begin
            // Counter only runs while a memory access is stalled; a timeout restarts it
            if (mem_phase_s && !mem_ready && !timeout_s) begin
                wait_cnt_s = wait_cnt_r + CW'(1);
            end else begin
                wait_cnt_s = {CW{1'b0}};
            end
            case (state_r)
                S_FETCH: begin
                    if (timeout_s) begin
                        bus_err = 1'b1;
                    end else begin
                        mem_read = 1'b1;
                        ir_write = mem_ready;
                        pc_write = mem_ready;
                        if (mem_ready) begin
                            next_state_s = S_DECODE;
                        end else begin
                            next_state_s = S_FETCH;
                        end
                    end
                end
                S_DECODE: begin
                    case (dec_s.cls)
                        C_J: begin
                            jump         = 1'b1;
                            pc_write     = 1'b1;
                            instr_done   = 1'b1;
                            next_state_s = S_FETCH;
                        end
                        C_JAL: begin
                            jump         = 1'b1;
                            pc_write     = 1'b1;
                            next_state_s = S_WB;
                        end
                        C_ILL: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                            next_state_s = S_TRAP;
`else
                            instr_done   = 1'b1;
                            next_state_s = S_FETCH;
`endif
                        end
                        default: next_state_s = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    alu_op       = dec_s.alu_op;
                    alu_src      = dec_s.alu_src;
                    sign_or_zero = dec_s.sign_or_zero;
                    case (dec_s.cls)
                        C_BEQ: begin
                            branch       = 1'b1;
                            pc_write     = zero;
                            instr_done   = 1'b1;
                            next_state_s = S_FETCH;
                        end
                        C_LW:    next_state_s = S_MEM;
                        C_SW:    next_state_s = S_MEM;
                        default: next_state_s = S_WB;
                    endcase
                end
                S_MEM: begin
                    alu_op       = dec_s.alu_op;
                    alu_src      = dec_s.alu_src;
                    sign_or_zero = dec_s.sign_or_zero;
                    if (timeout_s) begin
                        // Abandon the access: no strobes, no write-back
                        bus_err      = 1'b1;
                        next_state_s = S_FETCH;
                    end else begin
                        mem_read  = (dec_s.cls == C_LW);
                        mem_write = (dec_s.cls == C_SW);
                        if (!mem_ready) begin
                            next_state_s = S_MEM;
                        end else if (dec_s.cls == C_LW) begin
                            next_state_s = S_WB;
                        end else begin
                            instr_done   = 1'b1;
                            next_state_s = S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    alu_op       = dec_s.alu_op;
                    alu_src      = dec_s.alu_src;
                    sign_or_zero = dec_s.sign_or_zero;
                    reg_write    = 1'b1;
                    reg_dst      = dec_s.reg_dst;
                    mem_to_reg   = dec_s.mem_to_reg;
                    instr_done   = 1'b1;
                    next_state_s = S_FETCH;
                end
                S_TRAP:  next_state_s = S_TRAP;
                default: next_state_s = S_FETCH;
            endcase
        end
    end

    // State, latched opcode and wait counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_FETCH;
            op_q_r     <= 5'b00000;
            wait_cnt_r <= {CW{1'b0}};
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= wait_cnt_s;
            if (state_r == S_DECODE) begin
                op_q_r <= opcode;
            end else begin
                op_q_r <= op_q_r;
            end
        end
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_op <= 1'b0;
        end else if ((state_r == S_DECODE) && (dec_s.cls == C_ILL)) begin
            illegal_op <= 1'b1;
        end else begin
            illegal_op <= illegal_op;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios followed by
// randomized instruction streams, each checked cycle by cycle against a
// per-instruction path model built from opcode tables.
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    localparam int WAIT_MAX = 15;
    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_JAL = 5, K_ILL = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] opcode = 5'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, jump, branch, mem_read, mem_write;
    logic       alu_src, reg_write, sign_or_zero, instr_done, bus_err;
    logic [1:0] reg_dst, mem_to_reg;
    logic [3:0] alu_op;
    logic [2:0] state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;

    int         kind_t [32];
    logic [3:0] aop_t  [32];
    logic       src_t  [32];
    logic       soz_t  [32];
    logic [1:0] rd_t   [32];
    logic [4:0] legal_ops [12];

    multicycle_control #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .jump(jump), .branch(branch),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
        .sign_or_zero(sign_or_zero), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .state(state), .instr_done(instr_done), .bus_err(bus_err)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    always #5 clk = ~clk;

    logic [21:0] obs;
    assign obs = {pc_write, ir_write, jump, branch, mem_read, mem_write, alu_src, reg_write,
                  sign_or_zero, reg_dst, mem_to_reg, alu_op, state, instr_done, bus_err};

    // Expected output vector; fe selects the opcode's ALU fields, else neutral ones
    function automatic logic [21:0] vec(input logic pcw, irw, jmp, br, mrd, mwr, regw,
                                        input logic [2:0] st, input logic done, berr, fe,
                                        input logic [4:0] op, input logic [1:0] rd, m2r);
        return {pcw, irw, jmp, br, mrd, mwr, fe ? src_t[op] : 1'b0, regw,
                fe ? soz_t[op] : 1'b1, rd, m2r, fe ? aop_t[op] : 4'b0000, st, done, berr};
    endfunction

    task automatic chk_now(input string tag, input logic [21:0] e);
        chk_cnt++;
        assert (obs === e) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, e);
        end
    endtask

    task automatic chk(input string tag, input logic [21:0] e);
        @(negedge clk);
        chk_now(tag, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp1(input string tag, input logic [21:0] e);
        chk(tag, e);
        step();
    endtask

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    task automatic chk_ill(input string tag, input logic e);
        chk_cnt++;
        assert (illegal_op === e) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, illegal_op, e);
        end
    endtask
`endif

    task automatic set_op(input logic [4:0] op, input int k, input logic [3:0] a,
                          input logic s, input logic z, input logic [1:0] rd);
        kind_t[op] = k; aop_t[op] = a; src_t[op] = s; soz_t[op] = z; rd_t[op] = rd;
    endtask

    // One complete instruction: fw stalled fetch cycles, mw stalled memory cycles
    task automatic run_instr(input logic [4:0] op, input logic zv, input int fw,
                             input int mw, input bit rst_in_mem);
        int         kd;
        logic       is_lw;
        logic       to;
        logic [1:0] m2r;
        kd    = kind_t[op];
        is_lw = (kd == K_LW);
        m2r   = (kd == K_LW) ? 2'b01 : ((kd == K_JAL) ? 2'b10 : 2'b00);
        opcode = op;
        zero   = zv;
        for (int k = 0; k < fw; k++) begin
            mem_ready = 1'b0;
            to = ((k % (WAIT_MAX + 1)) == WAIT_MAX);
            exp1("fetch_wait", vec(0,0,0,0,!to,0,0, S_FETCH, 0, to, 0, op, 2'b00, 2'b00));
        end
        mem_ready = 1'b1;
        exp1("fetch", vec(1,1,0,0,1,0,0, S_FETCH, 0, 0, 0, op, 2'b00, 2'b00));
        mem_ready = 1'($urandom_range(0, 1));
        case (kd)
            K_J: begin
                exp1("dec_j", vec(1,0,1,0,0,0,0, S_DECODE, 1, 0, 0, op, 2'b00, 2'b00));
                return;
            end
            K_JAL: exp1("dec_jal", vec(1,0,1,0,0,0,0, S_DECODE, 0, 0, 0, op, 2'b00, 2'b00));
            K_ILL: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                exp1("dec_ill", vec(0,0,0,0,0,0,0, S_DECODE, 0, 0, 0, op, 2'b00, 2'b00));
                for (int k = 0; k < 3; k++) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    chk("trap", vec(0,0,0,0,0,0,0, S_TRAP, 0, 0, 0, op, 2'b00, 2'b00));
                    chk_ill("trap_flag", 1'b1);
                    step();
                end
                reset_n = 1'b0;
                #1;
                chk_now("trap_rst", vec(0,0,0,0,0,0,0, S_FETCH, 0, 0, 0, op, 2'b00, 2'b00));
                chk_ill("trap_flag_rst", 1'b0);
                step();
                reset_n = 1'b1;
`else
                exp1("dec_nop", vec(0,0,0,0,0,0,0, S_DECODE, 1, 0, 0, op, 2'b00, 2'b00));
`endif
                return;
            end
            default: exp1("decode", vec(0,0,0,0,0,0,0, S_DECODE, 0, 0, 0, op, 2'b00, 2'b00));
        endcase
        // Scramble the opcode input: later cycles must use the latched value
        opcode = 5'($urandom);
        if (kd != K_JAL) begin
            mem_ready = 1'($urandom_range(0, 1));
            if (kd == K_BEQ) begin
                exp1("exec_beq", vec(zv,0,0,1,0,0,0, S_EXEC, 1, 0, 1, op, 2'b00, 2'b00));
                return;
            end
            exp1("exec", vec(0,0,0,0,0,0,0, S_EXEC, 0, 0, 1, op, 2'b00, 2'b00));
            if (kd == K_LW || kd == K_SW) begin
                for (int k = 0; k < mw; k++) begin
                    mem_ready = 1'b0;
                    if (k == WAIT_MAX) begin
                        exp1("mem_timeout", vec(0,0,0,0,0,0,0, S_MEM, 0, 1, 1, op, 2'b00, 2'b00));
                        return;
                    end
                    if (rst_in_mem) begin
                        chk("mem_pre_rst", vec(0,0,0,0,is_lw,!is_lw,0, S_MEM, 0, 0, 1, op, 2'b00, 2'b00));
                        reset_n = 1'b0;
                        #1;
                        chk_now("mem_async_rst", vec(0,0,0,0,0,0,0, S_FETCH, 0, 0, 0, op, 2'b00, 2'b00));
                        step();
                        reset_n = 1'b1;
                        return;
                    end
                    exp1("mem_wait", vec(0,0,0,0,is_lw,!is_lw,0, S_MEM, 0, 0, 1, op, 2'b00, 2'b00));
                end
                mem_ready = 1'b1;
                exp1("mem_done", vec(0,0,0,0,is_lw,!is_lw,0, S_MEM, !is_lw, 0, 1, op, 2'b00, 2'b00));
                if (!is_lw) return;
            end
        end
        mem_ready = 1'($urandom_range(0, 1));
        exp1("wb", vec(0,0,0,0,0,0,1, S_WB, 1, 0, 1, op, rd_t[op], m2r));
    endtask

    initial begin
        int  idx;
        int  fw;
        int  mw;
        logic [4:0] rop;
        for (int i = 0; i < 32; i++) set_op(5'(i), K_ILL, 4'b0000, 1'b0, 1'b1, 2'b00);
        set_op(OP_ADD,   K_ALU, 4'b0000, 1'b0, 1'b1, 2'b01);
        set_op(OP_SLI,   K_ALU, 4'b0010, 1'b1, 1'b0, 2'b00);
        set_op(OP_ADDI,  K_ALU, 4'b0011, 1'b1, 1'b1, 2'b00);
        set_op(OP_SLTI,  K_ALU, 4'b0011, 1'b1, 1'b1, 2'b00);
        set_op(OP_SLTIU, K_ALU, 4'b1000, 1'b1, 1'b1, 2'b00);
        set_op(OP_ORI,   K_ALU, 4'b0101, 1'b1, 1'b0, 2'b00);
        set_op(OP_XORI,  K_ALU, 4'b0110, 1'b1, 1'b0, 2'b00);
        set_op(OP_LW,    K_LW,  4'b0011, 1'b1, 1'b1, 2'b00);
        set_op(OP_SW,    K_SW,  4'b0011, 1'b1, 1'b1, 2'b00);
        set_op(OP_BEQ,   K_BEQ, 4'b0001, 1'b0, 1'b1, 2'b00);
        set_op(OP_J,     K_J,   4'b0000, 1'b0, 1'b1, 2'b00);
        set_op(OP_JAL,   K_JAL, 4'b0000, 1'b0, 1'b1, 2'b10);
        legal_ops = '{OP_ADD, OP_SLI, OP_ADDI, OP_SLTI, OP_SLTIU, OP_ORI,
                      OP_XORI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL};

        // Reset: FETCH state but no fetch strobes, even with mem_ready high
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        chk("reset", vec(0,0,0,0,0,0,0, S_FETCH, 0, 0, 0, 5'd0, 2'b00, 2'b00));
        step();
        reset_n = 1'b1;

        run_instr(OP_ADD,   1'b0, 0, 0, 1'b0);
        run_instr(OP_LW,    1'b0, 0, 3, 1'b0);
        run_instr(OP_BEQ,   1'b1, 0, 0, 1'b0);
        run_instr(OP_BEQ,   1'b0, 0, 0, 1'b0);
        run_instr(OP_ADD,   1'b0, 16, 0, 1'b0);
        run_instr(OP_ADDI,  1'b0, 15, 0, 1'b0);
        run_instr(OP_SW,    1'b0, 0, 2, 1'b1);
        run_instr(OP_LW,    1'b0, 1, 16, 1'b0);
        run_instr(OP_SW,    1'b0, 0, 15, 1'b0);
        run_instr(OP_J,     1'b0, 0, 0, 1'b0);
        run_instr(OP_JAL,   1'b1, 2, 0, 1'b0);
        run_instr(5'b11111, 1'b0, 0, 0, 1'b0);
        run_instr(OP_ORI,   1'b0, 0, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            idx = $urandom_range(0, 12);
            rop = (idx == 12) ? 5'($urandom) : legal_ops[idx];
            fw  = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 2);
            mw  = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            run_instr(rop, 1'($urandom_range(0, 1)), fw, mw, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum consecutive mem_ready-low cycles tolerated in FETCH or MEM before a bus error.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  5  instruction opcode from the instruction register, sampled in DECODE.
REQ-005 zero  input  1  ALU zero flag, used in EXEC for beq.
REQ-006 mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-007 pc_write, ir_write, jump, branch, mem_read, mem_write, alu_src, reg_write, sign_or_zero  output  1 each  datapath strobes.
REQ-008 reg_dst, mem_to_reg  output  2 each  write-register select and write-back source select (00 ALU, 01 memory, 10 PC link).
REQ-009 alu_op  output  4  ALU operation code.
REQ-010 state  output  3  current FSM state, for debug.
REQ-011 instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
REQ-012 bus_err  output  1  one-cycle pulse on memory timeout.

Function
REQ-013 States SHALL be FETCH, DECODE, EXEC, MEM, WB and TRAP; transitions occur on the rising clk edge.
REQ-014 FETCH:
- mem_read=1.
- ir_write=pc_write=mem_ready (PC+4 update).
- Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
REQ-015 DECODE: lasts 1 cycle and latches opcode into op_q; all later outputs use op_q.
REQ-016 Opcode classes and state paths:
- R/I-ALU (00000 add, 00001 sli, 00111 addi, 01000 slti, 01001 sltiu, 01010 ori, 01011 xori): DECODE->EXEC->WB->FETCH.
- lw 00100: EXEC->MEM->WB->FETCH.
- sw 00101: EXEC->MEM->FETCH.
- beq 00110: EXEC->FETCH.
- j 00010: DECODE->FETCH.
- jal 00011: DECODE->WB->FETCH.
REQ-017 In DECODE, j and jal SHALL assert jump=1 and pc_write=1.
REQ-018 In EXEC, beq SHALL assert branch=1 and pc_write=zero.
REQ-019 Field values per opcode, held from EXEC through WB:
- alu_op: add 0000, sli 0010, lw/sw/addi/slti 0011, sltiu 1000, ori 0101, xori 0110, beq 0001.
- alu_src=1 for all immediate ops and lw/sw.
- sign_or_zero=0 for sli, ori and xori; otherwise 1.
REQ-020 MEM asserts mem_read (lw) or mem_write (sw) while mem_ready=0 and in the completing cycle; it advances only on mem_ready=1.
REQ-021 WB asserts reg_write=1 for one cycle with:
- add: reg_dst=01, mem_to_reg=00.
- immediate ops: reg_dst=00, mem_to_reg=00.
- lw: reg_dst=00, mem_to_reg=01.
- jal: reg_dst=10, mem_to_reg=10.
REQ-022 No output SHALL be asserted outside the states listed above; all unlisted strobes SHALL be 0.
REQ-023 instr_done SHALL pulse in the final state of each path: WB, sw MEM completion, beq EXEC, or j DECODE.
REQ-024 Memory wait counter:
- Width $clog2(WAIT_MAX+1).
- Increments each FETCH/MEM cycle with mem_ready=0.
- Clears on mem_ready=1 or on any state change.
REQ-025 Timeout: when the counter equals WAIT_MAX with mem_ready=0, the block SHALL pulse bus_err, deassert all memory strobes that cycle, go to FETCH and write no register.
REQ-026 If mem_ready=1 arrives in the same cycle the timeout fires, the access completes and bus_err SHALL NOT pulse.
REQ-027 Undefined opcodes are handled per REQ-031.

Reset
REQ-028 reset_n=0 SHALL asynchronously force:
- state=FETCH, op_q=00000 and the wait counter to 0.
- All strobes, instr_done and bus_err to 0.
- reg_dst, mem_to_reg and alu_op to 0; sign_or_zero to 1.
REQ-029 While reset_n=0, FETCH strobes SHALL be suppressed (mem_read=0).
REQ-030 Reset asserted mid-instruction SHALL abandon the instruction with no partial write.

Configuration
REQ-031 Macro MC_CTRL_ILLEGAL_TRAP_EN:
- Defined: an undefined opcode in DECODE goes to TRAP. TRAP asserts no strobes, holds a sticky illegal_op output at 1, and is left only by reset.
- Undefined: illegal_op is absent, and an undefined opcode behaves as a NOP (DECODE->FETCH with instr_done pulse).

Structure
REQ-032 Package mc_ctrl_pkg SHALL hold:
- The state enum.
- The 5-bit opcode constants.
- The 4-bit alu_op constants.
- The reg_dst and mem_to_reg select constants.
REQ-033 One sub-module, mc_decode, SHALL provide a combinational op_q-to-class/field lookup; the FSM and counter live in multicycle_control.

Verification
REQ-034 add with mem_ready=1 always: FETCH,DECODE,EXEC,WB; reg_write=1 in WB with reg_dst=01; instr_done at cycle 4.
REQ-035 lw with mem_ready low 3 cycles in MEM: MEM held 4 cycles with mem_read=1; WB mem_to_reg=01; no bus_err.
REQ-036 beq with zero=1, then zero=0: pc_write=1 in EXEC for the first, 0 for the second; each takes 3 cycles.
REQ-037 WAIT_MAX=15 with mem_ready stuck 0 in FETCH: bus_err pulses in the 16th wait cycle; state stays FETCH; counter restarts.
REQ-038 reset_n=0 asserted in MEM of sw: mem_write drops immediately (asynchronously); state=FETCH after release; opcode 11111 traps with MC_CTRL_ILLEGAL_TRAP_EN defined, and NOPs in 2 cycles without it.
